rename_stall_ctrl: RTL and testbench

- Decides each cycle whether the Decode→Rename pipeline latch may advance; drives that latch's stall input.
- Checks the bundle currently held in Rename against free physical registers, Active List, Issue Queue and LSQ space.
- Sequences post-flush recovery cycles while the rename map table is being restored.
- Flags back-end starvation when stalls persist.

---
 rtl/rename_stall_ctrl.sv | 129 ++++++++++++
 tb/tb_rename_stall_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rename_stall_ctrl.sv
// Decode->Rename advance control: resource fit check, post-flush recovery sequencing, starvation flag.
// Optional stall-cycle performance counter enabled by defining RENAME_STALL_PERF_EN.
module rename_stall_ctrl #(
    parameter int WIDTH          = 4,
    parameter int FL_CNT_W       = 7,
    parameter int AL_CNT_W       = 7,
    parameter int IQ_CNT_W       = 6,
    parameter int LSQ_CNT_W      = 5,
    parameter int RECOVER_CYCLES = 2,
    parameter int STARVE_LIMIT   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_i,
    input  logic                 bundleValid_i,
    input  logic [WIDTH-1:0]     destValid_i,
    input  logic [WIDTH-1:0]     ldst_i,
    input  logic [FL_CNT_W-1:0]  freeRegCnt_i,
    input  logic [AL_CNT_W-1:0]  alFreeCnt_i,
    input  logic [IQ_CNT_W-1:0]  iqFreeCnt_i,
    input  logic [LSQ_CNT_W-1:0] lsqFreeCnt_i,
    output logic                 stall_o,
    output logic                 renameFire_o,
    output logic [3:0]           stallCause_o,
    output logic [1:0]           state_o,
    output logic                 starve_o,
    output logic [31:0]          perfStallCycles_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int RC_W  = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RECOVER_CYCLES - 1);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STALL   = 2'd1,
        ST_RECOVER = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [RC_W-1:0] rc_q, rc_d;
    logic [3:0]      cause_q, cause_d;
    logic [7:0]      starve_cnt_q, starve_cnt_d;
    logic            starve_q, starve_d;

    // Popcounts built as prefix-sum chains over the bundle slots.
    logic [CNT_W-1:0] dest_acc [WIDTH+1];
    logic [CNT_W-1:0] ldst_acc [WIDTH+1];
    assign dest_acc[0] = '0;
    assign ldst_acc[0] = '0;
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pop
        assign dest_acc[gi+1] = dest_acc[gi] + CNT_W'(destValid_i[gi]);
        assign ldst_acc[gi+1] = ldst_acc[gi] + CNT_W'(ldst_i[gi]);
    end

    logic fl_ok, al_ok, iq_ok, lsq_ok, fits, in_recover, blocked;
    assign fl_ok      = 32'(freeRegCnt_i) >= 32'(dest_acc[WIDTH]);
    assign al_ok      = 32'(alFreeCnt_i)  >= 32'(WIDTH);
    assign iq_ok      = 32'(iqFreeCnt_i)  >= 32'(WIDTH);
    assign lsq_ok     = 32'(lsqFreeCnt_i) >= 32'(ldst_acc[WIDTH]);
    assign fits       = fl_ok & al_ok & iq_ok & lsq_ok;
    assign in_recover = (state_q == ST_RECOVER);
    assign blocked    = bundleValid_i & ~fits;

    assign stall_o      = in_recover | blocked;
    assign renameFire_o = bundleValid_i & ~stall_o & ~flush_i;

    always_comb begin
        state_d      = state_q;
        rc_d         = rc_q;
        cause_d      = 4'b0000;
        starve_cnt_d = starve_cnt_q;
        starve_d     = starve_q;

        if (flush_i) begin
            state_d = ST_RECOVER;
            rc_d    = RC_LOAD;
        end else if (in_recover) begin
            if (rc_q == '0) state_d = ST_RUN;
            else            rc_d    = rc_q - 1'b1;
        end else begin
            state_d = blocked ? ST_STALL : ST_RUN;
        end

        if (blocked && !in_recover)
            cause_d = {~lsq_ok, ~iq_ok, ~al_ok, ~fl_ok};

        // Recovery stalls are expected work, so they never count toward starvation.
        if (flush_i || renameFire_o)
            starve_cnt_d = 8'd0;
        else if (stall_o && !in_recover && starve_cnt_q != 8'hFF)
            starve_cnt_d = starve_cnt_q + 8'd1;

        starve_d = flush_i ? 1'b0 : (starve_q | (starve_cnt_d >= LIMIT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            rc_q         <= '0;
            cause_q      <= 4'b0000;
            starve_cnt_q <= 8'd0;
            starve_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rc_q         <= rc_d;
            cause_q      <= cause_d;
            starve_cnt_q <= starve_cnt_d;
            starve_q     <= starve_d;
        end
    end

    assign stallCause_o = cause_q;
    assign state_o      = state_q;
    assign starve_o     = starve_q;

`ifdef RENAME_STALL_PERF_EN
    logic [31:0] perf_q;
    always_ff @(posedge clk) begin
        if (reset)        perf_q <= 32'd0;
        else if (stall_o) perf_q <= perf_q + 32'd1;
    end
    assign perfStallCycles_o = perf_q;
`else
    assign perfStallCycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_rename_stall_ctrl.sv
// Directed-vector bench for rename_stall_ctrl: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them.
module tb_rename_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush_i = 1'b0;
    logic        bundleValid_i = 1'b0;
    logic [3:0]  destValid_i = 4'b0;
    logic [3:0]  ldst_i = 4'b0;
    logic [6:0]  freeRegCnt_i = 7'd0;
    logic [6:0]  alFreeCnt_i = 7'd0;
    logic [5:0]  iqFreeCnt_i = 6'd0;
    logic [4:0]  lsqFreeCnt_i = 5'd0;
    logic        stall_o, renameFire_o, starve_o;
    logic [3:0]  stallCause_o;
    logic [1:0]  state_o;
    logic [31:0] perfStallCycles_o;

    rename_stall_ctrl dut (
        .clk(clk), .reset(reset), .flush_i(flush_i), .bundleValid_i(bundleValid_i),
        .destValid_i(destValid_i), .ldst_i(ldst_i), .freeRegCnt_i(freeRegCnt_i),
        .alFreeCnt_i(alFreeCnt_i), .iqFreeCnt_i(iqFreeCnt_i), .lsqFreeCnt_i(lsqFreeCnt_i),
        .stall_o(stall_o), .renameFire_o(renameFire_o), .stallCause_o(stallCause_o),
        .state_o(state_o), .starve_o(starve_o), .perfStallCycles_o(perfStallCycles_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        bit          chk;
        logic        stall;
        logic        fire;
        logic [3:0]  cause;
        logic [1:0]  state;
        logic        starve;
        logic [31:0] perf;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_miss = 0;
    logic [31:0] perf_model = 32'd0;

    // Shadow inputs applied at the next step.
    logic       s_rst, s_flush, s_bv;
    logic [3:0] s_dv, s_ld;
    logic [6:0] s_fl, s_al;
    logic [5:0] s_iq;
    logic [4:0] s_lsq;

    task automatic defaults();
        s_rst = 1'b0; s_flush = 1'b0; s_bv = 1'b1;
        s_dv = 4'b1111; s_ld = 4'b0000;
        s_fl = 7'd64; s_al = 7'd64; s_iq = 6'd32; s_lsq = 5'd16;
    endtask

    task automatic step(input string nm, input logic es, input logic ef,
                        input logic [3:0] ec, input logic [1:0] est, input logic esv);
        exp_t e;
        @(posedge clk);
        #1;
        reset = s_rst; flush_i = s_flush; bundleValid_i = s_bv;
        destValid_i = s_dv; ldst_i = s_ld; freeRegCnt_i = s_fl;
        alFreeCnt_i = s_al; iqFreeCnt_i = s_iq; lsqFreeCnt_i = s_lsq;
        e.nm = nm; e.chk = !s_rst; e.stall = es; e.fire = ef;
        e.cause = ec; e.state = est; e.starve = esv;
`ifdef RENAME_STALL_PERF_EN
        e.perf = perf_model;
`else
        e.perf = 32'd0;
`endif
        sb_q.push_back(e);
        perf_model = s_rst ? 32'd0 : perf_model + {31'd0, es};
    endtask

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s.%s: got %0h, required %0h", nm, fld, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            if (mon_e.chk) begin
                n_vec++;
                chk(mon_e.nm, "stall",  {31'd0, stall_o},      {31'd0, mon_e.stall});
                chk(mon_e.nm, "fire",   {31'd0, renameFire_o}, {31'd0, mon_e.fire});
                chk(mon_e.nm, "cause",  {28'd0, stallCause_o}, {28'd0, mon_e.cause});
                chk(mon_e.nm, "state",  {30'd0, state_o},      {30'd0, mon_e.state});
                chk(mon_e.nm, "starve", {31'd0, starve_o},     {31'd0, mon_e.starve});
                chk(mon_e.nm, "perf",   perfStallCycles_o,     mon_e.perf);
                $display("vec %-12s stall=%0b fire=%0b cause=%b state=%0d starve=%0b perf=%0d",
                         mon_e.nm, stall_o, renameFire_o, stallCause_o, state_o, starve_o, perfStallCycles_o);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        defaults();
        s_rst = 1'b1;
        step("rst0", 0, 0, 0, 0, 0);
        step("rst1", 0, 0, 0, 0, 0);

        // Free-list pressure and exact boundary.
        defaults(); s_fl = 7'd4;
        step("fit_fl4", 0, 1, 4'b0000, 2'd0, 0);
        s_fl = 7'd3;
        step("fl3_a", 1, 0, 4'b0000, 2'd0, 0);
        step("fl3_b", 1, 0, 4'b0001, 2'd1, 0);
        s_fl = 7'd4;
        step("fl4_a", 0, 1, 4'b0001, 2'd1, 0);
        step("fl4_b", 0, 1, 4'b0000, 2'd0, 0);

        // Combined AL + LSQ shortage.
        defaults(); s_ld = 4'b0110; s_lsq = 5'd1; s_al = 7'd3;
        step("al_lsq_a", 1, 0, 4'b0000, 2'd0, 0);
        step("al_lsq_b", 1, 0, 4'b1010, 2'd1, 0);
        defaults();
        step("rel_a", 0, 1, 4'b1010, 2'd1, 0);
        step("rel_b", 0, 1, 4'b0000, 2'd0, 0);

        // IQ one short, then exactly WIDTH.
        s_iq = 6'd3;
        step("iq3", 1, 0, 4'b0000, 2'd0, 0);
        s_iq = 6'd4;
        step("iq4", 0, 1, 4'b0100, 2'd1, 0);
        defaults();
        step("iq_clr", 0, 1, 4'b0000, 2'd0, 0);

        // No valid bundle: never stalls; empty bundle fits with zero free regs.
        s_bv = 1'b0; s_fl = 7'd0;
        step("nobv_a", 0, 0, 4'b0000, 2'd0, 0);
        step("nobv_b", 0, 0, 4'b0000, 2'd0, 0);
        s_bv = 1'b1; s_dv = 4'b0000;
        step("nodest", 0, 1, 4'b0000, 2'd0, 0);

        // Single flush: two recovery cycles; cause stays clear in RECOVER.
        defaults(); s_flush = 1'b1;
        step("fl1_f", 0, 0, 4'b0000, 2'd0, 0);
        s_flush = 1'b0; s_fl = 7'd0;
        step("fl1_r1", 1, 0, 4'b0000, 2'd2, 0);
        step("fl1_r2", 1, 0, 4'b0000, 2'd2, 0);
        s_fl = 7'd64;
        step("fl1_run", 0, 1, 4'b0000, 2'd0, 0);

        // Flush again inside the first recovery cycle restarts the count.
        s_flush = 1'b1;
        step("fl2_f", 0, 0, 4'b0000, 2'd0, 0);
        step("fl2_f2", 1, 0, 4'b0000, 2'd2, 0);
        s_flush = 1'b0;
        step("fl2_r1", 1, 0, 4'b0000, 2'd2, 0);
        step("fl2_r2", 1, 0, 4'b0000, 2'd2, 0);
        step("fl2_run", 0, 1, 4'b0000, 2'd0, 0);

        // Reset mid-recovery, asserted together with flush.
        s_flush = 1'b1;
        step("rr_f", 0, 0, 4'b0000, 2'd0, 0);
        s_rst = 1'b1;
        step("rr_rst", 1, 0, 4'b0000, 2'd2, 0);
        defaults();
        step("rr_run", 0, 1, 4'b0000, 2'd0, 0);

        // Persistent stall: starve_o rises after the 255th stall cycle and sticks.
        s_fl = 7'd0;
        for (int k = 1; k <= 260; k++)
            step($sformatf("starve_%0d", k), 1, 0, (k == 1) ? 4'b0000 : 4'b0001,
                 (k == 1) ? 2'd0 : 2'd1, (k >= 256) ? 1'b1 : 1'b0);
        s_flush = 1'b1;
        step("sv_flush", 1, 0, 4'b0001, 2'd1, 1);
        s_flush = 1'b0; s_fl = 7'd64;
        step("sv_r1", 1, 0, 4'b0001, 2'd2, 0);
        step("sv_r2", 1, 0, 4'b0000, 2'd2, 0);
        step("sv_run", 0, 1, 4'b0000, 2'd0, 0);

        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (sb_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
